// File: rtl/l2_refill_pkg.sv
// Shared types and constants for the L2 DDR refill controller.
package l2_refill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } refillState_e;

    localparam int L2_LINES         = 512;
    localparam int L2_RESERVE_LINES = 1;
    localparam int DDR_BEAT_BYTES   = 16;

    // Occupancy in whole 8-word lines, a partly filled line counts as used.
    function automatic logic [9:0] usedLines(input logic [11:0] unreadWords);
        return {1'b0, unreadWords[11:3]} + {9'd0, |unreadWords[2:0]};
    endfunction

endpackage

// File: rtl/l2_refill_fifo.sv
// Return-beat buffer between the DDR read port and L2 port B.
// Push and pop may coincide at any occupancy; a pushed beat shows at the head
// only from the following cycle.
module l2_refill_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign doPop   = pop_i && (count_q != '0);
    assign doPush  = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);
    assign head_o  = mem_q[rdPtr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

    // Storage array, deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/l2_ddr_refill_ctrl.sv
// Refill controller: issues DDR burst reads from a programmed base address,
// buffers the returned beats and writes them into L2 port B, throttled by L2
// occupancy and stalled while the L1/DDR conflict flag is high.
module l2_ddr_refill_ctrl
    import l2_refill_pkg::*;
#(
    parameter int BURST_BEATS = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int DDR_ADDR_W  = 28
) (
    input  logic                  clk_166M66,
    input  logic                  mcu_sys_rst,
    input  logic                  i_refill_start,
    input  logic [DDR_ADDR_W-1:0] i_refill_base_addr,
    input  logic                  i_refill_stop,
    output logic                  o_refill_busy,
    output logic                  o_ddr_cmd_valid,
    input  logic                  i_ddr_cmd_ready,
    output logic [DDR_ADDR_W-1:0] o_ddr_cmd_addr,
    input  logic                  i_ddr_rd_valid,
    input  logic [127:0]          i_ddr_rd_data,
    input  logic [11:0]           i_l2_unread_size,
    input  logic                  i_l1ddr_rw_confilicts,
    output logic                  o_ddr_operate_enable,
    output logic                  o_ddr_rw,
    output logic [127:0]          o_l2_wr_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DDR_ADDR_W-1:0] ADDR_STEP  = DDR_ADDR_W'(BURST_BEATS * DDR_BEAT_BYTES);
    localparam logic [DDR_ADDR_W-1:0] ALIGN_MASK = ~DDR_ADDR_W'(DDR_BEAT_BYTES - 1);
    localparam logic [15:0]           LINE_LIMIT = 16'(L2_LINES - L2_RESERVE_LINES);

    refillState_e          state_q,    state_d;
    logic [CNT_W-1:0]      pending_q,  pending_d;
    logic                  cmdValid_q, cmdValid_d;
    logic [DDR_ADDR_W-1:0] cmdAddr_q,  cmdAddr_d;

    logic                  cmdAccept;
    logic                  l2Write;
    logic                  spaceOk;
    logic [15:0]           pendAfterBurst;
    logic [127:0]          fifoHead;
    logic                  fifoEmpty;
    logic                  fifoFull;
    logic [CNT_W-1:0]      fifoCount;

    l2_refill_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (128)
    ) u_fifo (
        .clk_i   (clk_166M66),
        .rst_i   (mcu_sys_rst),
        .push_i  (i_ddr_rd_valid),
        .data_i  (i_ddr_rd_data),
        .pop_i   (l2Write),
        .head_o  (fifoHead),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull),
        .count_o (fifoCount)
    );

    assign cmdAccept            = cmdValid_q && i_ddr_cmd_ready;
    assign l2Write              = !fifoEmpty && !i_l1ddr_rw_confilicts && !mcu_sys_rst;
    assign o_ddr_operate_enable = l2Write;
    assign o_l2_wr_data         = (fifoEmpty || mcu_sys_rst) ? '0 : fifoHead;
    assign o_ddr_rw             = !mcu_sys_rst;
    assign o_refill_busy        = (state_q != IDLE);
    assign o_ddr_cmd_valid      = cmdValid_q;
    assign o_ddr_cmd_addr       = cmdAddr_q;

    // Next-state: pending count, space check against buffer and L2 lines, FSM and command handshake.
    always_comb begin
        pending_d = pending_q;
        if (cmdAccept) begin
            pending_d = pending_d + CNT_W'(BURST_BEATS);
        end
        if (l2Write) begin
            pending_d = pending_d - CNT_W'(1);
        end

        pendAfterBurst = 16'(pending_d) + 16'(BURST_BEATS);
        spaceOk = (pendAfterBurst <= 16'(FIFO_DEPTH)) &&
                  ((pendAfterBurst + 16'(usedLines(i_l2_unread_size))) <= LINE_LIMIT);

        state_d   = state_q;
        cmdAddr_d = cmdAddr_q;
        if (cmdAccept) begin
            cmdAddr_d = cmdAddr_q + ADDR_STEP;
        end

        case (state_q)
            IDLE: begin
                if (i_refill_start) begin
                    state_d   = RUN;
                    cmdAddr_d = i_refill_base_addr & ALIGN_MASK;
                end
            end
            RUN: begin
                if (i_refill_stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((pending_d == '0) && !cmdValid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmdValid_q && !i_ddr_cmd_ready) begin
            cmdValid_d = 1'b1;
        end else begin
            cmdValid_d = (state_d == RUN) && spaceOk;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            cmdValid_q <= 1'b0;
            cmdAddr_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            cmdValid_q <= cmdValid_d;
            cmdAddr_q  <= cmdAddr_d;
        end
    end

    // A beat landing on a full buffer, or more buffered beats than requested, means the DDR side misbehaved.
    always_ff @(posedge clk_166M66) begin
        if (!mcu_sys_rst) begin
            assert (!(i_ddr_rd_valid && fifoFull));
            assert (fifoCount <= pending_q);
        end
    end

endmodule

// File: tb/tb_l2_ddr_refill_ctrl.sv
// Directed bench for the L2 DDR refill controller with a small DDR responder
// and a write scoreboard.
module tb_l2_ddr_refill_ctrl;

    localparam int W = 28;

    logic         clock     = 1'b0;
    logic         reset     = 1'b1;
    logic         start     = 1'b0;
    logic [W-1:0] base      = '0;
    logic         stop      = 1'b0;
    logic         busy;
    logic         cmdValid;
    logic         cmdReady  = 1'b1;
    logic [W-1:0] cmdAddr;
    logic         rdValid   = 1'b0;
    logic [127:0] rdData    = '0;
    logic [11:0]  unread    = '0;
    logic         conflict  = 1'b0;
    logic         enable;
    logic         rw;
    logic [127:0] wrData;

    int           cyc          = 0;
    int           compared     = 0;
    int           mismatched   = 0;
    logic [127:0] sbData[$];
    int           sbCyc[$];
    int           beatDue[$];
    int           lastDue      = 0;
    int           due;
    int           beatSerial   = 0;
    int           pend         = 0;
    int           lastWrCyc    = 0;
    logic [W-1:0] expAddr      = '0;
    logic [W-1:0] acceptLog[$];
    bit           latencyCheck = 1'b1;
    bit           forceBeat    = 1'b0;
    bit           found;

    l2_ddr_refill_ctrl dut (
        .clk_166M66            (clock),
        .mcu_sys_rst           (reset),
        .i_refill_start        (start),
        .i_refill_base_addr    (base),
        .i_refill_stop         (stop),
        .o_refill_busy         (busy),
        .o_ddr_cmd_valid       (cmdValid),
        .i_ddr_cmd_ready       (cmdReady),
        .o_ddr_cmd_addr        (cmdAddr),
        .i_ddr_rd_valid        (rdValid),
        .i_ddr_rd_data         (rdData),
        .i_l2_unread_size      (unread),
        .i_l1ddr_rw_confilicts (conflict),
        .o_ddr_operate_enable  (enable),
        .o_ddr_rw              (rw),
        .o_l2_wr_data          (wrData)
    );

    always #3 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Pulse start with a base address; leaves the caller one cycle later.
    task automatic applyStimulus(input logic [W-1:0] baseAddr);
        base    = baseAddr;
        start   = 1'b1;
        expAddr = baseAddr & ~W'(15);
        acceptLog.delete();
        nextCycle();
        start = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        bit fell;
        int fallCyc;
        fell    = 1'b0;
        fallCyc = 0;
        for (int i = 0; i < 200 && !fell; i++) begin
            @(negedge clock);
            if (!busy) begin
                fell    = 1'b1;
                fallCyc = cyc;
            end
        end
        checkOutput({tag, "_idle"}, fell, 1);
        checkOutput({tag, "_busy_fall"}, fallCyc - lastWrCyc, 1);
        checkOutput({tag, "_sb_empty"}, sbData.size(), 0);
        nextCycle();
    endtask

    task automatic stopAndDrain(input string tag);
        stop = 1'b1;
        nextCycle();
        stop = 1'b0;
        waitIdle(tag);
    endtask

    // DDR responder: returns scheduled beats, forgets everything during reset.
    always @(posedge clock) begin
        #2;
        if (reset) begin
            beatDue.delete();
            sbData.delete();
            sbCyc.delete();
            pend    = 0;
            lastDue = 0;
            rdValid = forceBeat;
            rdData  = {4{32'hDEAD0000}};
        end else if (beatDue.size() > 0 && beatDue[0] <= cyc) begin
            void'(beatDue.pop_front());
            rdValid = 1'b1;
            rdData  = {32'(beatSerial), 32'hC0DE0000 ^ 32'(beatSerial * 7),
                       32'hF00D0000 + 32'(beatSerial), ~32'(beatSerial)};
            beatSerial++;
            sbData.push_back(rdData);
            sbCyc.push_back(cyc);
        end else begin
            rdValid = 1'b0;
        end
    end

    // Monitor: command addresses, pending bound, schedule beats, score L2 writes.
    always @(negedge clock) begin
        if (!reset) begin
            if (cmdValid && cmdReady) begin
                checkOutput("cmd_addr", cmdAddr, expAddr);
                acceptLog.push_back(cmdAddr);
                expAddr = expAddr + W'(128);
                pend += 8;
                checkOutput("pend_max", pend <= 16, 1);
                for (int k = 0; k < 8; k++) begin
                    due = (lastDue + 1 > cyc + 2) ? lastDue + 1 : cyc + 2;
                    beatDue.push_back(due);
                    lastDue = due;
                end
            end
            if (enable) begin
                checkOutput("wr_expected", sbData.size() > 0, 1);
                if (sbData.size() > 0) begin
                    checkOutput("wr_data", wrData, sbData[0]);
                    if (latencyCheck) begin
                        checkOutput("wr_latency", cyc - sbCyc[0], 1);
                    end
                    void'(sbData.pop_front());
                    void'(sbCyc.pop_front());
                    pend -= 1;
                    lastWrCyc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", cmdValid, 0);
        checkOutput("rst_addr", cmdAddr, 0);
        checkOutput("rst_enable", enable, 0);
        checkOutput("rst_rw", rw, 0);
        checkOutput("rst_wrdata", wrData, 0);
        nextCycle();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rw_after_rst", rw, 1);
        checkOutput("idle_valid", cmdValid, 0);
        nextCycle();

        // Basic refill from an aligned base
        applyStimulus(28'h0001230);
        @(negedge clock);
        checkOutput("start_valid", cmdValid, 1);
        checkOutput("start_addr", cmdAddr, 28'h0001230);
        repeat (30) nextCycle();

        // Stop while a command waits for ready
        cmdReady = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            found = cmdValid;
        end
        checkOutput("stop_valid_pending", found, 1);
        nextCycle();
        stop = 1'b1;
        nextCycle();
        stop = 1'b0;
        acceptLog.delete();
        repeat (3) begin
            @(negedge clock);
            checkOutput("stop_valid_held", cmdValid, 1);
            nextCycle();
        end
        cmdReady = 1'b1;
        waitIdle("stop");
        checkOutput("stop_one_accept", acceptLog.size(), 1);

        // Occupancy throttle including the partial-line and reserve boundaries
        unread   = 12'hFC0;
        cmdReady = 1'b0;
        applyStimulus(28'h0002000);
        repeat (3) begin
            @(negedge clock);
            checkOutput("thr_fc0_valid", cmdValid, 0);
            nextCycle();
        end
        unread = 12'hFB9;
        repeat (2) begin
            @(negedge clock);
            checkOutput("thr_fb9_valid", cmdValid, 0);
            nextCycle();
        end
        unread = 12'hFB8;
        @(negedge clock);
        checkOutput("thr_fb8_same_cycle", cmdValid, 0);
        nextCycle();
        @(negedge clock);
        checkOutput("thr_fb8_next_cycle", cmdValid, 1);
        nextCycle();
        cmdReady = 1'b1;
        nextCycle();
        stopAndDrain("thr");

        // Conflict stall with an unaligned base
        latencyCheck = 1'b0;
        applyStimulus(28'h0004567);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            found = rdValid;
        end
        checkOutput("cf_first_beat", found, 1);
        nextCycle();
        conflict = 1'b1;
        repeat (5) begin
            @(negedge clock);
            checkOutput("cf_enable_low", enable, 0);
            nextCycle();
        end
        conflict = 1'b0;
        repeat (4) begin
            @(negedge clock);
            checkOutput("cf_enable_run", enable, 1);
            nextCycle();
        end
        stopAndDrain("cf");
        latencyCheck = 1'b1;

        // Address wrap at the top of the DDR space
        unread = 12'h000;
        applyStimulus(28'hFFFFF80);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            found = (acceptLog.size() >= 2);
        end
        checkOutput("wrap_two_accepts", found, 1);
        if (acceptLog.size() >= 2) begin
            checkOutput("wrap_first", acceptLog[0], 28'hFFFFF80);
            checkOutput("wrap_second", acceptLog[1], 28'h0000000);
        end
        nextCycle();
        stopAndDrain("wrap");

        // Reset in the middle of a refill
        unread = 12'hFB8;
        applyStimulus(28'h0008000);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            found = (pend == 6);
        end
        checkOutput("mr_pend6_seen", found, 1);
        nextCycle();
        reset     = 1'b1;
        forceBeat = 1'b1;
        @(negedge clock);
        checkOutput("mr_enable_in_reset", enable, 0);
        nextCycle();
        forceBeat = 1'b0;
        @(negedge clock);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_valid", cmdValid, 0);
        checkOutput("mr_addr", cmdAddr, 0);
        checkOutput("mr_enable", enable, 0);
        checkOutput("mr_wrdata", wrData, 0);
        nextCycle();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checkOutput("mr_after_enable", enable, 0);
            checkOutput("mr_after_busy", busy, 0);
            nextCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
